// File: rtl/fractal_param_scheduler.sv
// fractal_param_scheduler
// Owns the working parameter set of the fractal generator (c, velocity, pixel
// pitch), advances it once per displayed frame and presents it on registered
// outputs that all change together in a single cycle.
module fractal_param_scheduler #(
  parameter int MUL_BITS = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_cfg_we,
  input  logic [3:0]         i_cfg_addr,
  input  logic [31:0]        i_cfg_wdata,
  input  logic [15:0]        i_width_in,
  input  logic [15:0]        i_height_in,
  input  logic               i_frame_start,
  output logic signed [31:0] o_cr_out,
  output logic signed [31:0] o_ci_out,
  output logic signed [31:0] o_dx_out,
  output logic signed [31:0] o_dy_out,
  output logic signed [31:0] o_x0_out,
  output logic signed [31:0] o_y0_out,
  output logic               o_params_valid,
  output logic               o_update,
  output logic               o_busy
);

  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(MUL_BITS) + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_STEP   = 3'd2,
    S_MUL    = 3'd3,
    S_COMMIT = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Configuration registers
  logic signed [DATA_W-1:0] r_cr_init;
  logic signed [DATA_W-1:0] r_ci_init;
  logic signed [DATA_W-1:0] r_vr_init;
  logic signed [DATA_W-1:0] r_vi_init;
  logic signed [DATA_W-1:0] r_cr_min;
  logic signed [DATA_W-1:0] r_cr_max;
  logic signed [DATA_W-1:0] r_ci_min;
  logic signed [DATA_W-1:0] r_ci_max;
  logic signed [DATA_W-1:0] r_dx_init;
  logic signed [DATA_W-1:0] r_dx_min;
  logic [4:0]               r_zoom_shift;
  logic                     r_run;
  logic                     r_restart_pending;

  // Working state
  logic signed [DATA_W-1:0] r_cr;
  logic signed [DATA_W-1:0] r_ci;
  logic signed [DATA_W-1:0] r_vr;
  logic signed [DATA_W-1:0] r_vi;
  logic signed [DATA_W-1:0] r_dx;

  // Sequential multiplier
  logic [DATA_W-1:0]   r_mcand;
  logic [MUL_BITS-1:0] r_mx;
  logic [MUL_BITS-1:0] r_my;
  logic [DATA_W-1:0]   r_acc_x;
  logic [DATA_W-1:0]   r_acc_y;
  logic [CNT_W-1:0]    r_cnt;

  logic                     w_restart_wr;
  logic                     w_restart;
  logic                     w_mul_last;
  logic [2*DATA_W-1:0]      w_re_next;
  logic [2*DATA_W-1:0]      w_im_next;
  logic signed [DATA_W-1:0] w_dx_step;
  logic signed [DATA_W-1:0] w_dx_next;
  logic                     w_unused;

  // Advance a coordinate by its velocity; on leaving [lo, hi] clamp to the
  // violated bound and reverse the velocity. Returns {position, velocity}.
  function automatic logic [2*DATA_W-1:0] bounce_step(
    input logic signed [DATA_W-1:0] pos,
    input logic signed [DATA_W-1:0] vel,
    input logic signed [DATA_W-1:0] lo,
    input logic signed [DATA_W-1:0] hi
  );
    logic signed [DATA_W:0]   s;
    logic signed [DATA_W:0]   lo_x;
    logic signed [DATA_W:0]   hi_x;
    logic signed [DATA_W-1:0] neg_vel;
    s       = $signed({pos[DATA_W-1], pos}) + $signed({vel[DATA_W-1], vel});
    lo_x    = $signed({lo[DATA_W-1], lo});
    hi_x    = $signed({hi[DATA_W-1], hi});
    neg_vel = -vel;
    if (s > hi_x) begin
      bounce_step = {hi, neg_vel};
    end else if (s < lo_x) begin
      bounce_step = {lo, neg_vel};
    end else begin
      bounce_step = {s[DATA_W-1:0], vel};
    end
  endfunction

  // Geometric zoom: dx shrinks by dx/2^shift, floored at dx_min.
  function automatic logic signed [DATA_W-1:0] zoom_step(
    input logic signed [DATA_W-1:0] dx,
    input logic signed [DATA_W-1:0] dmin,
    input logic [4:0]               sh
  );
    logic signed [DATA_W-1:0] n;
    n = dx - (dx >>> sh);
    if (sh == 5'd0) begin
      zoom_step = dx;
    end else if (n < dmin) begin
      zoom_step = dmin;
    end else begin
      zoom_step = n;
    end
  endfunction

  // The LSBs of the frame size vanish in the halving.
  assign w_unused = ^{i_width_in[0], i_height_in[0]};

  // A restart written this cycle counts as pending immediately so that LOAD
  // follows on the very next cycle.
  assign w_restart_wr = i_cfg_we && (i_cfg_addr == 4'd11) && i_cfg_wdata[1];
  assign w_restart    = r_restart_pending || w_restart_wr;
  assign w_mul_last   = (r_cnt == CNT_W'(MUL_BITS - 1));

  assign w_re_next = bounce_step(r_cr, r_vr, r_cr_min, r_cr_max);
  assign w_im_next = bounce_step(r_ci, r_vi, r_ci_min, r_ci_max);
  assign w_dx_step = zoom_step(r_dx, r_dx_min, r_zoom_shift);
  assign w_dx_next = (r_state == S_LOAD) ? r_dx_init : w_dx_step;

  // Config register file, written from the PS-side register port
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cr_init    <= '0;
      r_ci_init    <= '0;
      r_vr_init    <= '0;
      r_vi_init    <= '0;
      r_cr_min     <= '0;
      r_cr_max     <= '0;
      r_ci_min     <= '0;
      r_ci_max     <= '0;
      r_dx_init    <= '0;
      r_dx_min     <= '0;
      r_zoom_shift <= '0;
      r_run        <= 1'b0;
    end else if (i_cfg_we) begin
      case (i_cfg_addr)
        4'd0:    r_cr_init    <= i_cfg_wdata;
        4'd1:    r_ci_init    <= i_cfg_wdata;
        4'd2:    r_vr_init    <= i_cfg_wdata;
        4'd3:    r_vi_init    <= i_cfg_wdata;
        4'd4:    r_cr_min     <= i_cfg_wdata;
        4'd5:    r_cr_max     <= i_cfg_wdata;
        4'd6:    r_ci_min     <= i_cfg_wdata;
        4'd7:    r_ci_max     <= i_cfg_wdata;
        4'd8:    r_dx_init    <= i_cfg_wdata;
        4'd9:    r_dx_min     <= i_cfg_wdata;
        4'd10:   r_zoom_shift <= i_cfg_wdata[4:0];
        4'd11:   r_run        <= i_cfg_wdata[0];
        default: ;
      endcase
    end
  end

  // Restart request flag: a new write wins over the clear in LOAD
  always_ff @(posedge clk) begin
    if (reset) begin
      r_restart_pending <= 1'b0;
    end else if (w_restart_wr) begin
      r_restart_pending <= 1'b1;
    end else if (r_state == S_LOAD) begin
      r_restart_pending <= 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_restart) begin
          w_state_next = S_LOAD;
        end else if (i_frame_start && r_run) begin
          w_state_next = S_STEP;
        end
      end
      S_LOAD:   w_state_next = S_MUL;
      S_STEP:   w_state_next = S_MUL;
      S_MUL:    w_state_next = w_mul_last ? S_COMMIT : S_MUL;
      S_COMMIT: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    o_busy   = (r_state != S_IDLE);
    o_update = (r_state == S_COMMIT);
  end

  // Working state: loaded from init registers or advanced one frame
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cr <= '0;
      r_ci <= '0;
      r_vr <= '0;
      r_vi <= '0;
      r_dx <= '0;
    end else if (r_state == S_LOAD) begin
      r_cr <= r_cr_init;
      r_ci <= r_ci_init;
      r_vr <= r_vr_init;
      r_vi <= r_vi_init;
      r_dx <= w_dx_next;
    end else if (r_state == S_STEP) begin
      r_cr <= w_re_next[2*DATA_W-1:DATA_W];
      r_vr <= w_re_next[DATA_W-1:0];
      r_ci <= w_im_next[2*DATA_W-1:DATA_W];
      r_vi <= w_im_next[DATA_W-1:0];
      r_dx <= w_dx_next;
    end
  end

  // Shift-add multiplier: both half-extents times the new dx, low 32 bits kept
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand <= '0;
      r_mx    <= '0;
      r_my    <= '0;
      r_acc_x <= '0;
      r_acc_y <= '0;
      r_cnt   <= '0;
    end else if ((r_state == S_LOAD) || (r_state == S_STEP)) begin
      r_mcand <= w_dx_next;
      r_mx    <= MUL_BITS'(i_width_in[15:1]);
      r_my    <= MUL_BITS'(i_height_in[15:1]);
      r_acc_x <= '0;
      r_acc_y <= '0;
      r_cnt   <= '0;
    end else if (r_state == S_MUL) begin
      r_acc_x <= r_acc_x + (r_mx[0] ? r_mcand : '0);
      r_acc_y <= r_acc_y + (r_my[0] ? r_mcand : '0);
      r_mcand <= r_mcand << 1;
      r_mx    <= r_mx >> 1;
      r_my    <= r_my >> 1;
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  // Output registers: all six parameters change together at COMMIT
  always_ff @(posedge clk) begin
    if (reset) begin
      o_cr_out       <= '0;
      o_ci_out       <= '0;
      o_dx_out       <= '0;
      o_dy_out       <= '0;
      o_x0_out       <= '0;
      o_y0_out       <= '0;
      o_params_valid <= 1'b0;
    end else if (r_state == S_COMMIT) begin
      o_cr_out       <= r_cr;
      o_ci_out       <= r_ci;
      o_dx_out       <= r_dx;
      o_dy_out       <= r_dx;
      o_x0_out       <= r_acc_x;
      o_y0_out       <= r_acc_y;
      o_params_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fractal_param_scheduler.sv
// Directed bench for fractal_param_scheduler with a reference model feeding
// an expected-output queue that is drained at each update.
module tb_fractal_param_scheduler;

  logic               clk = 1'b0;
  logic               reset;
  logic               cfg_we;
  logic [3:0]         cfg_addr;
  logic [31:0]        cfg_wdata;
  logic [15:0]        width_in;
  logic [15:0]        height_in;
  logic               frame_start;
  logic signed [31:0] cr_out, ci_out, dx_out, dy_out, x0_out, y0_out;
  logic               params_valid, update, busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] cr;
    logic [31:0] ci;
    logic [31:0] dx;
    logic [31:0] x0;
    logic [31:0] y0;
  } exp_t;

  exp_t sb[$];

  logic signed [31:0] cfg [12];
  logic signed [31:0] m_cr, m_ci, m_vr, m_vi, m_dx;

  fractal_param_scheduler #(.MUL_BITS(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_cfg_we       (cfg_we),
    .i_cfg_addr     (cfg_addr),
    .i_cfg_wdata    (cfg_wdata),
    .i_width_in     (width_in),
    .i_height_in    (height_in),
    .i_frame_start  (frame_start),
    .o_cr_out       (cr_out),
    .o_ci_out       (ci_out),
    .o_dx_out       (dx_out),
    .o_dy_out       (dy_out),
    .o_x0_out       (x0_out),
    .o_y0_out       (y0_out),
    .o_params_valid (params_valid),
    .o_update       (update),
    .o_busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_cfg(input logic [3:0] a, input logic [31:0] d);
    if (a <= 4'd9)       cfg[a] = d;
    else if (a == 4'd10) cfg[10] = {27'd0, d[4:0]};
    else if (a == 4'd11) cfg[11] = {31'd0, d[0]};
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    tick();
    cfg_we    = 1'b0;
    model_cfg(a, d);
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic m_bounce(inout logic signed [31:0] p, inout logic signed [31:0] v,
                          input logic signed [31:0] lo, input logic signed [31:0] hi);
    longint s;
    s = longint'(p) + longint'(v);
    if (s > longint'(hi)) begin
      p = hi;
      v = -v;
    end else if (s < longint'(lo)) begin
      p = lo;
      v = -v;
    end else begin
      p = 32'(s);
    end
  endtask

  task automatic model_load();
    m_cr = cfg[0];
    m_ci = cfg[1];
    m_vr = cfg[2];
    m_vi = cfg[3];
    m_dx = cfg[8];
  endtask

  task automatic model_step();
    logic signed [31:0] n;
    m_bounce(m_cr, m_vr, cfg[4], cfg[5]);
    m_bounce(m_ci, m_vi, cfg[6], cfg[7]);
    if (cfg[10] != 0) begin
      n = m_dx - (m_dx >>> cfg[10][4:0]);
      m_dx = (n < cfg[9]) ? cfg[9] : n;
    end
  endtask

  task automatic push_exp();
    exp_t e;
    logic [63:0] px, py;
    px   = {32'd0, m_dx} * {49'd0, width_in[15:1]};
    py   = {32'd0, m_dx} * {49'd0, height_in[15:1]};
    e.cr = m_cr;
    e.ci = m_ci;
    e.dx = m_dx;
    e.x0 = px[31:0];
    e.y0 = py[31:0];
    sb.push_back(e);
  endtask

  // Waits for the update pulse, checks its latency, then compares the
  // committed outputs against the head of the expectation queue.
  task automatic wait_update(input int n_exp);
    int   n = 0;
    logic seen = 1'b0;
    exp_t e;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (update === 1'b1) begin
        seen = 1'b1;
        break;
      end
      n++;
      @(posedge clk);
      #1;
    end
    check("update_seen", {31'd0, seen}, 32'd1);
    check("update_latency", n, n_exp);
    if (seen) begin
      tick();
      check("queue_nonempty", {31'd0, (sb.size() > 0)}, 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("cr_out", cr_out, e.cr);
        check("ci_out", ci_out, e.ci);
        check("dx_out", dx_out, e.dx);
        check("dy_out", dy_out, e.dx);
        check("x0_out", x0_out, e.x0);
        check("y0_out", y0_out, e.y0);
      end
      check("params_valid", {31'd0, params_valid}, 32'd1);
      check("update_after", {31'd0, update}, 32'd0);
      check("busy_after", {31'd0, busy}, 32'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cr"}, cr_out, 32'd0);
    check({tag, "_ci"}, ci_out, 32'd0);
    check({tag, "_dx"}, dx_out, 32'd0);
    check({tag, "_dy"}, dy_out, 32'd0);
    check({tag, "_x0"}, x0_out, 32'd0);
    check({tag, "_y0"}, y0_out, 32'd0);
    check({tag, "_pv"}, {31'd0, params_valid}, 32'd0);
    check({tag, "_update"}, {31'd0, update}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic watch_quiet(input string tag, input int cycles);
    int n_upd = 0;
    int n_busy = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (update !== 1'b0) n_upd++;
      if (busy !== 1'b0) n_busy++;
    end
    @(posedge clk);
    #1;
    check({tag, "_updates"}, n_upd, 32'd0);
    check({tag, "_busy_cycles"}, n_busy, 32'd0);
  endtask

  initial begin
    reset       = 1'b1;
    cfg_we      = 1'b0;
    cfg_addr    = '0;
    cfg_wdata   = '0;
    width_in    = '0;
    height_in   = '0;
    frame_start = 1'b0;
    for (int i = 0; i < 12; i++) cfg[i] = '0;
    m_cr = '0; m_ci = '0; m_vr = '0; m_vi = '0; m_dx = '0;
    repeat (3) tick();
    reset = 1'b0;
    check_all_zero("reset");

    // First restart: pitch and origin from the frame size
    width_in  = 16'd640;
    height_in = 16'd480;
    wr(4'd8, 32'h0001_0000);
    cfg_we = 1'b1; cfg_addr = 4'd11; cfg_wdata = 32'd2;
    tick();
    cfg_we = 1'b0;
    model_cfg(4'd11, 32'd2);
    model_load();
    push_exp();
    wait_update(17);
    check("t1_dx", dx_out, 32'h0001_0000);
    check("t1_x0", x0_out, 32'h0140_0000);
    check("t1_y0", y0_out, 32'h00F0_0000);

    // Bounce against cr_max
    wr(4'd0, 32'h0F00_0000);
    wr(4'd2, 32'h0200_0000);
    wr(4'd5, 32'h1000_0000);
    wr(4'd11, 32'd3);
    model_load();
    push_exp();
    wait_update(17);
    check("bounce_load_cr", cr_out, 32'h0F00_0000);
    pulse_frame();
    model_step();
    push_exp();
    wait_update(17);
    check("bounce_f1_cr", cr_out, 32'h1000_0000);
    pulse_frame();
    model_step();
    push_exp();
    wait_update(17);
    check("bounce_f2_cr", cr_out, 32'h0E00_0000);

    // Zoom with dx_min clamp
    wr(4'd8, 32'h0000_0100);
    wr(4'd10, 32'd1);
    wr(4'd9, 32'h0000_0060);
    wr(4'd11, 32'd3);
    model_load();
    push_exp();
    wait_update(17);
    check("zoom_load_dx", dx_out, 32'h0000_0100);
    pulse_frame(); model_step(); push_exp(); wait_update(17);
    check("zoom_f1_dx", dx_out, 32'h0000_0080);
    pulse_frame(); model_step(); push_exp(); wait_update(17);
    check("zoom_f2_dx", dx_out, 32'h0000_0060);
    pulse_frame(); model_step(); push_exp(); wait_update(17);
    check("zoom_f3_dx", dx_out, 32'h0000_0060);

    // frame_start while busy is dropped
    pulse_frame();
    model_step();
    push_exp();
    repeat (4) tick();
    pulse_frame();
    wait_update(12);
    watch_quiet("busy_drop", 20);

    // Restart and frame_start together: restart wins
    cfg_we = 1'b1; cfg_addr = 4'd11; cfg_wdata = 32'd3; frame_start = 1'b1;
    tick();
    cfg_we = 1'b0; frame_start = 1'b0;
    model_cfg(4'd11, 32'd3);
    model_load();
    push_exp();
    wait_update(17);
    check("simul_cr", cr_out, 32'h0F00_0000);
    check("simul_dx", dx_out, 32'h0000_0100);

    // Reset in the middle of the multiply
    pulse_frame();
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) cfg[i] = '0;
    m_cr = '0; m_ci = '0; m_vr = '0; m_vi = '0; m_dx = '0;
    sb.delete();
    check_all_zero("midmul_reset");
    pulse_frame();
    watch_quiet("after_reset", 30);
    check("after_reset_pv", {31'd0, params_valid}, 32'd0);
    check("sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
